instr_prefetch_queue: RTL

In-order instruction prefetch queue between instruction memory and the decode stage. Generates sequential fetch addresses, tracks outstanding memory requests, buffers returned words with their PCs, and presents one instruction per cycle to the decode-stage controller inputs (opcode/funct3/funct7b5 are sliced from `InstrD`). Handles decode stalls and execute-stage redirects, discarding stale in-flight responses.

---
 rtl/instr_prefetch_queue_if.sv | 26 ++
 rtl/instr_prefetch_queue.sv | 128 ++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue_if.sv
// Instruction-memory request/response bus between instr_prefetch_queue (master) and memory (slave).
interface instr_prefetch_queue_if #(
  parameter int XLEN = 64
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// In-order instruction prefetch queue feeding decode; drops stale responses after a redirect.
// Optional feature macro PREFETCH_BYPASS_EN: present a response to decode in its arrival cycle when the queue is empty.
module instr_prefetch_queue #(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  instr_prefetch_queue_if.master imem,
  input  logic                   RedirectE,
  input  logic [XLEN-1:0]        PCTargetE,
  input  logic                   StallD,
  output logic                   ValidD,
  output logic [31:0]            InstrD,
  output logic [XLEN-1:0]        PCD,
  output logic [XLEN-1:0]        PCPlus4D
);

  localparam int              CW  = $clog2(DEPTH + 1);
  localparam int              PW  = $clog2(DEPTH);
  localparam logic [31:0]     NOP = 32'h0000_0013;
  localparam logic [CW:0]     CAP = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   discard;
  logic [31:0]     instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];

  logic            req_fire;
  logic            rsp_keep;
  logic            bypass;
  logic            push;
  logic            pop;
  logic            full;
  logic [XLEN-1:0] target_aligned;

  assign target_aligned = PCTargetE & ~XLEN'(3);
  assign full           = (count == CW'(DEPTH));

  // Credits: queued entries plus outstanding requests never exceed DEPTH, so a response always has a slot.
  assign imem.imem_req_valid = rst_n && !RedirectE &&
                               (({1'b0, count} + {1'b0, inflight}) < CAP);
  assign imem.imem_addr      = fetch_pc;
  assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;

  assign rsp_keep = imem.imem_rsp_valid && !RedirectE && (discard == '0);
  assign pop      = (count != '0) && !StallD;

`ifdef PREFETCH_BYPASS_EN
  assign bypass = rsp_keep && (count == '0);
  assign push   = rsp_keep && (!bypass || StallD);
`else
  assign bypass = 1'b0;
  assign push   = rsp_keep;
`endif

  always_comb begin
    ValidD = 1'b0;
    InstrD = NOP;
    PCD    = '0;
    if (bypass) begin
      ValidD = 1'b1;
      InstrD = imem.imem_rsp_data;
      PCD    = rsp_pc;
    end else if (count != '0) begin
      ValidD = 1'b1;
      InstrD = instr_q[head];
      PCD    = pc_q[head];
    end
  end

  assign PCPlus4D = PCD + XLEN'(4);

  // A redirect flushes the queue and marks every outstanding request (less one answered now) for discard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
    end else if (RedirectE) begin
      fetch_pc <= target_aligned;
      rsp_pc   <= target_aligned;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= inflight - CW'(imem.imem_rsp_valid);
      discard  <= inflight - CW'(imem.imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (rsp_keep) begin
        rsp_pc <= rsp_pc + XLEN'(4);
      end
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count    <= count + CW'(push) - CW'(pop);
      inflight <= inflight + CW'(req_fire) - CW'(imem.imem_rsp_valid);
      if (imem.imem_rsp_valid && (discard != '0)) begin
        discard <= discard - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[tail] <= imem.imem_rsp_data;
      pc_q[tail]    <= rsp_pc;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule
